// File: rtl/stream_sel_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stream_sel_ctrl
//  Purpose  : Frame-synchronous A/B pixel source selector with a single-frame
//             snapshot (freeze) sequencer in front of the frame-buffer writer.
//  Revision : 1.0  initial release
// ============================================================================
module stream_sel_ctrl #(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2,     // must be >= 2
    parameter int CNT_W       = 16
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iSEL,
    input  logic              iSNAP,
    input  logic              iFVAL,
    input  logic [DATA_W-1:0] iA_R,
    input  logic [DATA_W-1:0] iA_G,
    input  logic [DATA_W-1:0] iA_B,
    input  logic              iA_DVAL,
    input  logic [DATA_W-1:0] iB_R,
    input  logic [DATA_W-1:0] iB_G,
    input  logic [DATA_W-1:0] iB_B,
    input  logic              iB_DVAL,
    output logic [DATA_W-1:0] oR,
    output logic [DATA_W-1:0] oG,
    output logic [DATA_W-1:0] oB,
    output logic              oDVAL,
    output logic              oSEL,
    output logic              oFROZEN,
    output logic [CNT_W-1:0]  oFRAME_CNT
);

    localparam logic [2:0] ST_RUN         = 3'd0;
    localparam logic [2:0] ST_SNAP_WAIT   = 3'd1;
    localparam logic [2:0] ST_SNAP_CAPT   = 3'd2;
    localparam logic [2:0] ST_FROZEN      = 3'd3;
    localparam logic [2:0] ST_RESUME_WAIT = 3'd4;

    logic [SYNC_STAGES-1:0] sel_sync;
    logic [SYNC_STAGES-1:0] snap_sync;
    logic                   sel_s;
    logic                   snap_s;
    logic                   snap_s_q;
    logic                   fval_q;
    logic                   armed;
    logic                   snap_rise;
    logic                   fval_rise;
    logic                   fval_fall;
    logic                   sel_applied;
    logic                   eff_sel;
    logic [2:0]             state;
    logic [2:0]             state_nxt;
    logic                   wr_en;
    logic                   wr_en_eff;
    logic                   frozen;
    logic                   cnt_en;

    // Synchronize the asynchronous operator controls into the pixel clock domain
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sel_sync  <= '0;
            snap_sync <= '0;
        end else begin
            sel_sync  <= {sel_sync[SYNC_STAGES-2:0], iSEL};
            snap_sync <= {snap_sync[SYNC_STAGES-2:0], iSNAP};
        end
    end

    assign sel_s  = sel_sync[SYNC_STAGES-1];
    assign snap_s = snap_sync[SYNC_STAGES-1];

    // Edge history; arming waits for a low FVAL so a partial frame after reset is ignored
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            snap_s_q <= 1'b0;
            fval_q   <= 1'b0;
            armed    <= 1'b0;
        end else begin
            snap_s_q <= snap_s;
            fval_q   <= iFVAL;
            armed    <= armed | ~iFVAL;
        end
    end

    assign snap_rise = snap_s & ~snap_s_q;
    assign fval_rise = iFVAL & ~fval_q & armed;
    assign fval_fall = ~iFVAL & fval_q & armed;

    // The new source is used already on the frame-start cycle itself
    assign eff_sel = fval_rise ? sel_s : sel_applied;

    // Latch the requested source only at a frame start
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sel_applied <= 1'b0;
        end else if (fval_rise) begin
            sel_applied <= sel_s;
        end
    end

    assign oSEL = sel_applied;

    // Snapshot sequencer state register
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Snapshot sequencer next-state logic; snap requests only act in RUN and FROZEN
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:         if (snap_rise) state_nxt = ST_SNAP_WAIT;
            ST_SNAP_WAIT:   if (fval_rise) state_nxt = ST_SNAP_CAPT;
            ST_SNAP_CAPT:   if (fval_fall) state_nxt = ST_FROZEN;
            ST_FROZEN:      if (snap_rise) state_nxt = ST_RESUME_WAIT;
            ST_RESUME_WAIT: if (fval_rise) state_nxt = ST_RUN;
            default:                       state_nxt = ST_RUN;
        endcase
    end

    // Per-state write enable, plus the resume frame's first cycle, and frame counting
    always_comb begin
        wr_en  = 1'b0;
        frozen = 1'b0;
        case (state)
            ST_RUN, ST_SNAP_WAIT, ST_SNAP_CAPT: wr_en  = 1'b1;
            ST_FROZEN:                          frozen = 1'b1;
            default:                            ;
        endcase
        wr_en_eff = wr_en | ((state == ST_RESUME_WAIT) & fval_rise);
        cnt_en    = fval_fall & wr_en;
    end

    assign oFROZEN = frozen;

    // Registered pixel mux and gated write strobe
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oR    <= '0;
            oG    <= '0;
            oB    <= '0;
            oDVAL <= 1'b0;
        end else begin
            oR    <= eff_sel ? iA_R : iB_R;
            oG    <= eff_sel ? iA_G : iB_G;
            oB    <= eff_sel ? iA_B : iB_B;
            oDVAL <= (eff_sel ? iA_DVAL : iB_DVAL) & wr_en_eff;
        end
    end

    // Count frames that end while writing is enabled; wraps naturally
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oFRAME_CNT <= '0;
        end else if (cnt_en) begin
            oFRAME_CNT <= oFRAME_CNT + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_sel_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_sel_ctrl
//  Purpose  : Self-checking bench for stream_sel_ctrl with a behavioural model
//  Revision : 1.0  initial release
// ============================================================================
module tb_stream_sel_ctrl;

    localparam int DATA_W = 12;
    localparam int SYNC   = 2;
    localparam int CNT_W  = 4;
    localparam int VB     = 6;   // vertical blank cycles before each frame
    localparam int HB     = 2;   // horizontal blank cycles after each line

    localparam int M_LIVE    = 0;  // writing normally
    localparam int M_ARMED   = 1;  // snapshot requested, finishing current frame
    localparam int M_CAPTURE = 2;  // writing the snapshot frame
    localparam int M_HOLD    = 3;  // frozen
    localparam int M_REARM   = 4;  // resume requested, waiting for frame start

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              iSEL = 1'b0, iSNAP = 1'b0, iFVAL = 1'b0;
    logic [DATA_W-1:0] iA_R = '0, iA_G = '0, iA_B = '0;
    logic [DATA_W-1:0] iB_R = '0, iB_G = '0, iB_B = '0;
    logic              iA_DVAL = 1'b0, iB_DVAL = 1'b0;
    logic [DATA_W-1:0] oR, oG, oB;
    logic              oDVAL, oSEL, oFROZEN;
    logic [CNT_W-1:0]  oFRAME_CNT;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0, wr_a = 0, wr_b = 0;

    stream_sel_ctrl #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC), .CNT_W(CNT_W)) dut (
        .iCLK(clk), .iRST_N(rst_n), .iSEL(iSEL), .iSNAP(iSNAP), .iFVAL(iFVAL),
        .iA_R(iA_R), .iA_G(iA_G), .iA_B(iA_B), .iA_DVAL(iA_DVAL),
        .iB_R(iB_R), .iB_G(iB_G), .iB_B(iB_B), .iB_DVAL(iB_DVAL),
        .oR(oR), .oG(oG), .oB(oB), .oDVAL(oDVAL), .oSEL(oSEL),
        .oFROZEN(oFROZEN), .oFRAME_CNT(oFRAME_CNT)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] dut_pack();
        return {21'b0, oR, oG, oB, oDVAL, oSEL, oFROZEN, oFRAME_CNT};
    endfunction

    // ---------------- behavioural model ----------------
    bit                sel_line[$];
    bit                snap_line[$];
    bit                m_snap_prev = 0, m_fval_prev = 0, m_armed = 0, m_src = 0;
    int                mode = M_LIVE;
    logic [DATA_W-1:0] e_r = '0, e_g = '0, e_b = '0;
    bit                e_dval = 0;
    int                e_cnt = 0;

    function automatic logic [63:0] exp_pack();
        return {21'b0, e_r, e_g, e_b, e_dval, m_src, (mode == M_HOLD), CNT_W'(e_cnt)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_line.delete();
            snap_line.delete();
            for (int i = 0; i < SYNC; i++) begin
                sel_line.push_back(1'b0);
                snap_line.push_back(1'b0);
            end
            m_snap_prev = 0; m_fval_prev = 0; m_armed = 0; m_src = 0;
            mode = M_LIVE;
            e_r = '0; e_g = '0; e_b = '0; e_dval = 0; e_cnt = 0;
        end else begin
            bit start, stop, snap_req, use_a, writing;
            start    = iFVAL && !m_fval_prev && m_armed;
            stop     = !iFVAL && m_fval_prev && m_armed;
            snap_req = snap_line[0] && !m_snap_prev;
            use_a    = start ? sel_line[0] : m_src;
            writing  = (mode == M_LIVE) || (mode == M_ARMED) || (mode == M_CAPTURE) ||
                       (mode == M_REARM && start);
            e_r    = use_a ? iA_R : iB_R;
            e_g    = use_a ? iA_G : iB_G;
            e_b    = use_a ? iA_B : iB_B;
            e_dval = (use_a ? iA_DVAL : iB_DVAL) && writing;
            if (stop && mode != M_HOLD && mode != M_REARM)
                e_cnt = (e_cnt + 1) % (1 << CNT_W);
            if      (mode == M_LIVE    && snap_req) mode = M_ARMED;
            else if (mode == M_ARMED   && start)    mode = M_CAPTURE;
            else if (mode == M_CAPTURE && stop)     mode = M_HOLD;
            else if (mode == M_HOLD    && snap_req) mode = M_REARM;
            else if (mode == M_REARM   && start)    mode = M_LIVE;
            if (start) m_src = sel_line[0];
            m_snap_prev = snap_line[0];
            void'(sel_line.pop_front());
            void'(snap_line.pop_front());
            sel_line.push_back(iSEL);
            snap_line.push_back(iSNAP);
            m_fval_prev = iFVAL;
            m_armed = m_armed || !iFVAL;
        end
    end

    // Per-cycle compare against the model and write tallies
    always @(negedge clk) begin
        check("cycle", dut_pack(), exp_pack());
        if (oDVAL) begin
            wr_cnt++;
            if (oR == 12'h111 && oG == 12'h111 && oB == 12'h111) wr_a++;
            if (oR == 12'h222 && oG == 12'h222 && oB == 12'h222) wr_b++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_pix(input bit rnd);
        if (rnd) begin
            iA_R = 12'($urandom); iA_G = 12'($urandom); iA_B = 12'($urandom);
            iB_R = 12'($urandom); iB_G = 12'($urandom); iB_B = 12'($urandom);
            iA_DVAL = ($urandom_range(0, 3) != 0);
            iB_DVAL = ($urandom_range(0, 3) != 0);
        end else begin
            iA_R = 12'h111; iA_G = 12'h111; iA_B = 12'h111;
            iB_R = 12'h222; iB_G = 12'h222; iB_B = 12'h222;
            iA_DVAL = 1'b1; iB_DVAL = 1'b1;
        end
    endtask

    task automatic drive_blank(input bit rnd);
        drive_pix(rnd);
        iA_DVAL = 1'b0;
        iB_DVAL = 1'b0;
    endtask

    // snap_mode: 0 none, 1 pulse mid-frame, 2 rise coincident with frame start
    task automatic run_frame(input int w, input int h, input bit rnd, input int snap_mode,
                             input int sel_mid, input int rst_line,
                             output int writes, output int wa, output int wb);
        int w0, a0, b0;
        w0 = wr_cnt; a0 = wr_a; b0 = wr_b;
        for (int i = 0; i < VB; i++) begin
            @(negedge clk);
            iFVAL = 1'b0;
            drive_blank(rnd);
            if (snap_mode == 2 && i == VB - SYNC) iSNAP = 1'b1;
        end
        for (int l = 0; l < h; l++) begin
            for (int p = 0; p < w + HB; p++) begin
                @(negedge clk);
                iFVAL = 1'b1;
                if (p < w) drive_pix(rnd); else drive_blank(rnd);
                if (p == 0 && l == 1) begin
                    if (snap_mode == 1) iSNAP = 1'b1;
                    if (snap_mode == 2) iSNAP = 1'b0;
                    if (sel_mid >= 0) iSEL = sel_mid[0];
                end
                if (p == 0 && l == 2 && snap_mode == 1) iSNAP = 1'b0;
                if (p == 0 && l == rst_line) begin
                    #2 rst_n = 1'b0;
                    #1 check("reset_async", dut_pack(), 64'd0);
                    @(negedge clk);
                    @(negedge clk);
                    rst_n = 1'b1;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            iFVAL = 1'b0;
            drive_blank(rnd);
        end
        @(negedge clk);
        #1;
        writes = wr_cnt - w0;
        wa = wr_a - a0;
        wb = wr_b - b0;
    endtask

    initial begin
        int wr, wa, wb;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("reset_state", dut_pack(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Source change requested mid-frame takes effect at the next frame
        iSEL = 1'b0;
        run_frame(8, 4, 0, 0, 1, -1, wr, wa, wb);
        check("sel_f1_b_pixels", wb, 32);
        check("sel_f1_osel", oSEL, 0);
        run_frame(8, 4, 0, 0, -1, -1, wr, wa, wb);
        check("sel_f2_a_pixels", wa, 32);
        check("sel_f2_osel", oSEL, 1);
        run_frame(8, 4, 0, 0, -1, -1, wr, wa, wb);
        check("sel_f3_a_pixels", wa, 32);
        check("sel_cnt", oFRAME_CNT, 3);

        // Snapshot: finish current frame, capture the next, then freeze
        run_frame(8, 4, 0, 1, -1, -1, wr, wa, wb);
        check("snap_f0_writes", wr, 32);
        run_frame(8, 4, 0, 0, -1, -1, wr, wa, wb);
        check("snap_f1_writes", wr, 32);
        check("snap_frozen", oFROZEN, 1);
        run_frame(8, 4, 0, 0, -1, -1, wr, wa, wb);
        check("snap_f2_writes", wr, 0);
        run_frame(8, 4, 0, 0, -1, -1, wr, wa, wb);
        check("snap_f3_writes", wr, 0);
        check("snap_cnt", oFRAME_CNT, 5);
        check("model_snap_cnt", e_cnt, 5);

        // Resume: requesting frame not written, next frame fully written
        run_frame(8, 4, 0, 1, -1, -1, wr, wa, wb);
        check("resume_req_writes", wr, 0);
        check("resume_req_frozen", oFROZEN, 0);
        run_frame(8, 4, 0, 0, -1, -1, wr, wa, wb);
        check("resume_writes", wr, 32);
        check("resume_cnt", oFRAME_CNT, 6);

        // Snap request coincident with frame start
        run_frame(8, 4, 0, 2, -1, -1, wr, wa, wb);
        check("coinc_cur_writes", wr, 32);
        check("coinc_cur_frozen", oFROZEN, 0);
        run_frame(8, 4, 0, 0, -1, -1, wr, wa, wb);
        check("coinc_capt_writes", wr, 32);
        check("coinc_frozen", oFROZEN, 1);
        run_frame(8, 4, 0, 2, -1, -1, wr, wa, wb);
        check("coinc_resume_req_writes", wr, 0);
        run_frame(8, 4, 0, 0, -1, -1, wr, wa, wb);
        check("coinc_resume_writes", wr, 32);
        check("coinc_cnt", oFRAME_CNT, 9);
        check("model_coinc_cnt", e_cnt, 9);

        // Randomized frames, sources and snapshot requests
        for (int f = 0; f < 14; f++) begin
            int sm;
            sm = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0;
            run_frame(int'($urandom_range(3, 10)), int'($urandom_range(3, 5)), 1, sm,
                      int'($urandom_range(0, 1)), -1, wr, wa, wb);
        end
        iSNAP = 1'b0;

        // Reset mid-frame: partial frame discarded, next frame counted
        run_frame(8, 4, 0, 0, -1, 2, wr, wa, wb);
        check("rst_partial_cnt", oFRAME_CNT, 0);
        check("rst_partial_frozen", oFROZEN, 0);
        run_frame(8, 4, 0, 0, -1, -1, wr, wa, wb);
        check("rst_next_cnt", oFRAME_CNT, 1);

        // Counter wrap: 17 frames total on a 4-bit counter
        for (int f = 0; f < 16; f++)
            run_frame(4, 2, 1, 0, int'($urandom_range(0, 1)), -1, wr, wa, wb);
        check("wrap_cnt", oFRAME_CNT, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
